// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: address and control sequencer for an in-place radix-2
// decimation-in-frequency FFT running on a single shared butterfly PE.
// One butterfly is issued per non-stalled cycle. Each stage is followed by a
// short read gap so that the stage's last write-back lands before the next
// stage reads. Results are left in bit-reversed order.
module fft_seq_ctrl #(
  parameter int LOG2N  = 5,
  parameter int RD_LAT = 2,
  localparam int SW    = (LOG2N < 3) ? 3 : LOG2N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int KW = LOG2N - 1;
  localparam int GW = $clog2(RD_LAT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]       state;
  logic [SW-1:0]    s_cnt;
  logic [KW-1:0]    k_cnt;
  logic [GW-1:0]    gap_cnt;

  // write-back delay line: valid bit plus both wing addresses per slot
  logic [RD_LAT-1:0] dl_v;
  logic [LOG2N-1:0]  dl_a [RD_LAT];
  logic [LOG2N-1:0]  dl_b [RD_LAT];

  logic             advance;
  logic             iss_v;
  logic [SW-1:0]    iss_s;
  logic [KW-1:0]    iss_k;
  logic             last_k;
  logic             last_s;
  logic             pending;

  logic [SW-1:0]    sh;
  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] base;
  logic [LOG2N-1:0] nx_a;
  logic [LOG2N-1:0] nx_b;
  logic [KW-1:0]    nx_tw;

  // Decide whether a butterfly issues this cycle and which (stage, index) it is.
  // A start in IDLE issues butterfly (0,0) on the same edge, so reads appear
  // the cycle right after start is sampled. Stall is ignored while idle.
  always_comb begin
    advance = (state == IDLE) || !stall;
    iss_v   = 1'b0;
    iss_s   = s_cnt;
    iss_k   = k_cnt;
    if (state == IDLE) begin
      iss_v = start;
      iss_s = '0;
      iss_k = '0;
    end else if (state == ISSUE) begin
      iss_v = !stall;
    end
    last_k  = &iss_k;
    last_s  = (iss_s == SW'(LOG2N - 1));
    pending = |dl_v;
  end

  // Butterfly addressing: span halves each stage; the group base is the
  // group index scaled by two spans, and the twiddle step doubles per stage.
  always_comb begin
    sh    = SW'(LOG2N - 1) - iss_s;
    k_ext = {1'b0, iss_k};
    span  = LOG2N'(1) << sh;
    pos   = k_ext & (span - LOG2N'(1));
    grp   = k_ext >> sh;
    base  = grp << (sh + SW'(1));
    nx_a  = base | pos;
    nx_b  = nx_a + span;
    nx_tw = KW'(pos << iss_s);
  end

  // Main sequencer: walks butterflies within a stage, inserts the read gap
  // between stages, and waits for the delay line to drain before done.
  // The done cycle is still spent in FINISH so a start there is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_cnt   <= '0;
      k_cnt   <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (iss_v) begin
        busy  <= 1'b1;
        s_cnt <= iss_s;
        if (last_k) begin
          k_cnt <= '0;
          if (last_s) begin
            state <= FINISH;
          end else begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end else begin
          k_cnt <= iss_k + KW'(1);
          state <= ISSUE;
        end
      end else if (state == GAP && !stall) begin
        if (gap_cnt == GW'(RD_LAT - 1)) begin
          s_cnt <= s_cnt + SW'(1);
          k_cnt <= '0;
          state <= ISSUE;
        end else begin
          gap_cnt <= gap_cnt + GW'(1);
        end
      end else if (state == FINISH) begin
        if (done) begin
          state <= IDLE;
        end else if (!stall && !pending) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

  // Registered read-side outputs; addresses and stage hold whenever nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      stage     <= '0;
    end else begin
      rd_en <= advance && iss_v;
      if (advance && iss_v) begin
        rd_addr_a <= nx_a;
        rd_addr_b <= nx_b;
        tw_addr   <= nx_tw;
        stage     <= iss_s;
      end
    end
  end

  // Delay line tracking in-flight butterflies; it shifts only on non-stalled
  // cycles so write-back stays aligned with the stalled datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else if (advance) begin
      dl_v[0] <= iss_v;
      dl_a[0] <= nx_a;
      dl_b[0] <= nx_b;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  // Registered write-back outputs taken from the tail of the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      wr_en <= advance && dl_v[RD_LAT-1];
      if (advance && dl_v[RD_LAT-1]) begin
        wr_addr_a <= dl_a[RD_LAT-1];
        wr_addr_b <= dl_b[RD_LAT-1];
      end
    end
  end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequences one in-place radix-2 decimation-in-frequency FFT of N = 2^LOG2N complex points through the shared butterfly PE.
- Per butterfly it generates:
  - two sample-memory read addresses,
  - the twiddle-ROM address,
  - the delayed write-back addresses and enables, aligned to the datapath read/PE pipeline latency.
- Sits between the top-level FFT control (start/done) and the sample RAM, twiddle ROM and PE.
- Output data is left in bit-reversed order.

Parameters:
- LOG2N, 5, log2 of transform length (N=32).
- RD_LAT, 2, cycles from rd_en/rd_addr to write-back of the corresponding PE result (RAM read + PE output register); must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin transform; sampled only in IDLE.
- stall  in  1  freeze all sequencing and the write-back delay line this cycle.
- busy  out  1  transform in progress.
- done  out  1  one-cycle pulse after the final write-back.
- stage  out  LOG2N bits (3 min)  current issuing stage index.
- rd_en  out  1  read both sample-memory ports this cycle.
- rd_addr_a  out  LOG2N  upper-wing sample address.
- rd_addr_b  out  LOG2N  lower-wing sample address.
- tw_addr  out  LOG2N-1  twiddle ROM index (W_N^tw_addr).
- wr_en  out  1  write PE results (out0/out1 -> addr_a, out2/out3 -> addr_b).
- wr_addr_a  out  LOG2N  write address for the sum output.
- wr_addr_b  out  LOG2N  write address for the twiddled-difference output.

Behaviour:
- All outputs are registered. On reset every output and internal counter is 0 and the FSM is in IDLE. Reset mid-transform aborts immediately: no done pulse, no further wr_en.
- FSM states: IDLE, ISSUE, GAP, FINISH.
  - IDLE: start=1 -> ISSUE with s=0, k=0. Outputs go valid the next cycle (cycle 1 if start is sampled at edge 0).
  - ISSUE: one butterfly per non-stalled cycle, k = 0..N/2-1.
    - After k=N/2-1: -> GAP if s < LOG2N-1, else -> FINISH.
  - GAP: rd_en=0 for exactly RD_LAT non-stalled cycles, so the last write of stage s lands before the first read of stage s+1. Then s++, k=0, -> ISSUE.
  - FINISH: wait for the delay line to empty. The cycle after the last wr_en: done=1 for one cycle, busy=0, -> IDLE.
- Addressing for stage s, butterfly k (all unsigned, LOG2N-bit):
  - span = N>>(s+1)
  - pos = k & (span-1)
  - grp = k >> (LOG2N-1-s)
  - rd_addr_a = grp*2*span + pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << s (truncated to LOG2N-1 bits; the final stage gives tw_addr=0).
- Write-back delay line:
  - An RD_LAT-deep shift register of {valid, addr_a, addr_b}.
  - wr_en/wr_addr_* equal the rd_en/rd_addr_* issued RD_LAT non-stalled cycles earlier.
- busy: 1 from the first ISSUE cycle through the last wr_en cycle inclusive; 0 in the done cycle.
- start while busy: ignored. start in the same cycle done pulses: ignored (state is FINISH). It is accepted the next cycle.
- stall=1:
  - Counters, FSM and delay line hold.
  - rd_en=0 and wr_en=0 for that cycle; addresses hold their values.
  - The datapath gates its read/PE registers with the same stall.
  - stall in IDLE has no effect.
- Timing for defaults, no stall, start at edge 0:
  - Stage s reads occupy cycles 1+18s .. 16+18s.
  - The last read is in cycle 88 and the last write in cycle 90.
  - done=1 in cycle 91.
  - Total reads = total writes = 80.

Test Plan:
- Reset, then start pulse -> cycle 1: rd_en=1, rd_addr_a=0, rd_addr_b=16, tw_addr=0, stage=0. Cycle 3: wr_en=1, wr_addr_a=0, wr_addr_b=16.
- Full run, no stall -> exactly 80 rd_en and 80 wr_en cycles. rd_en=0 in cycles 17-18, 35-36, 53-54, 71-72. done single pulse in cycle 91, busy high in cycles 1-90.
- Address spot checks:
  - s=1, k=5 -> a=5, b=13, tw=10.
  - s=2, k=5 -> a=9, b=13, tw=4.
  - s=4, k=7 -> a=14, b=15, tw=0.
  - Every stage covers each address 0..31 exactly once across a/b.
- stall held 3 cycles at stage 2, k=8 -> rd_en/wr_en=0 for those 3 cycles, sequence resumes unchanged, done moves to cycle 94.
- start asserted mid-run and in the done cycle -> ignored; a new start in IDLE produces an identical second run.
- rst_n low at cycle 40 for 1 cycle -> all outputs 0 asynchronously, no done, IDLE. A subsequent start restarts from s=0, k=0.
